// File: rtl/borrow_skip_subtractor_seq.sv
// -----------------------------------------------------------------------------
// borrow_skip_subtractor_seq
//
// Multi-cycle subtractor computing diff = a - b - bin (mod 2^WIDTH).
// The operands are consumed one 4-bit block per clock, least significant
// block first. Each block has a borrow-skip path: when every bit pair in the
// block is equal, the block's borrow-in is forwarded directly to its
// borrow-out instead of rippling through the four bit cells.
//
// Configuration macro: BORROW_SKIP_SUB_SKIP_STATS_EN
//   defined   : skip_cnt counts the blocks that took the skip path
//   undefined : skip_cnt is tied to 0 and no counter is built
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_valid   operand request
//   in_ready   high while IDLE (also high during reset)
//   a, b, bin  minuend, subtrahend, borrow-in (captured on accept)
//   out_valid  result available (state DONE)
//   out_ready  consumer accepts the result
//   diff       a - b - bin
//   bout       final borrow: 1 iff a < b + bin (unsigned)
//   ovf        signed overflow
//   skip_cnt   number of skipped blocks for this operation
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The source may change or drop its data on the cycle after the
// transfer; valid never depends on ready on either side of this block.
// -----------------------------------------------------------------------------
module borrow_skip_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              bin,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  diff,
  output logic                              bout,
  output logic                              ovf,
  output logic [$clog2(WIDTH/4+1)-1:0]      skip_cnt
);

  localparam int NBLK = WIDTH / 4;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CNTW = $clog2(NBLK + 1);
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   blk_idx_q, blk_idx_d;
  // Borrow entering the current block. Loaded with bin on accept so block 0
  // needs no special case.
  logic              br_q, br_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  // Current block datapath
  logic [3:0]        a_blk, b_blk, d_blk;
  logic [4:0]        br_chain;
  logic              prop;
  logic              blk_bout;
  logic              last_blk;

  always_comb begin
    a_blk = a_q[{blk_idx_q, 2'b00} +: 4];
    b_blk = b_q[{blk_idx_q, 2'b00} +: 4];

    br_chain    = '0;
    br_chain[0] = br_q;
    d_blk       = '0;
    for (int i = 0; i < 4; i++) begin
      d_blk[i]      = a_blk[i] ^ b_blk[i] ^ br_chain[i];
      br_chain[i+1] = (~a_blk[i] & b_blk[i]) | (~(a_blk[i] ^ b_blk[i]) & br_chain[i]);
    end

    // Equal blocks cannot generate or kill a borrow, so the incoming
    // borrow is forwarded past the ripple chain.
    prop     = (a_blk == b_blk);
    blk_bout = prop ? br_q : br_chain[4];
    last_blk = (blk_idx_q == IDXW'(NBLK - 1));
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    blk_idx_d = blk_idx_q;
    br_d      = br_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          br_d      = bin;
          blk_idx_d = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        diff_d[{blk_idx_q, 2'b00} +: 4] = d_blk;
        br_d      = blk_bout;
        blk_idx_d = blk_idx_q + 1'b1;
        if (last_blk) begin
          state_d = DONE;
          bout_d  = blk_bout;
          // d_blk[3] is the MSB of the final diff on the last block.
          ovf_d   = (a_q[MSB] != b_q[MSB]) && (d_blk[3] != a_q[MSB]);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      blk_idx_q <= '0;
      br_q      <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      blk_idx_q <= blk_idx_d;
      br_q      <= br_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BORROW_SKIP_SUB_SKIP_STATS_EN
  logic [CNTW-1:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (state_q == IDLE && in_valid) begin
      skip_cnt_d = '0;
    end else if (state_q == BUSY && prop) begin
      skip_cnt_d = skip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt_q <= '0;
    end else begin
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign skip_cnt = skip_cnt_q;
`else
  assign skip_cnt = {CNTW{1'b0}};
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
